// File: rtl/load_store_unit_if.sv
// CPU-side request/response bundle and word-wide memory port of the load/store unit.
// Both are plain wires; handshaking is start/busy/done on the CPU side and fixed 1-cycle read latency on the memory side.
interface lsu_cpu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    modport master (output start, op, addr, wdata, input busy, done, err, rdata);
    modport slave  (input start, op, addr, wdata, output busy, done, err, rdata);
endinterface

interface lsu_mem_if;
    logic        memWE;
    logic [31:0] memAddr;
    logic [31:0] memDataOut;
    logic [31:0] memDataIn;

    modport master (output memWE, memAddr, memDataOut, input memDataIn);
    modport slave  (input memWE, memAddr, memDataOut, output memDataIn);
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per request, sub-word stores by read-modify-write, big-endian lanes.
// Latency accept->done: loads 3, SW 2, SH/SB 4, error 1; start is ignored while busy, so the CPU must wait for done.
module load_store_unit #(
    parameter logic [31:0] ADDR_LO = 32'h3000,
    parameter logic [31:0] ADDR_HI = 32'h3FFF
) (
    input  logic      clk,
    input  logic      reset,
    lsu_cpu_if.slave  cpu,
    lsu_mem_if.master mem
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_EXT,
        S_WR,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        misaligned;
    logic        out_of_range;
    logic        req_bad;
    logic        accept;
    logic        subword_store;
    logic [31:0] word_addr;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged_nxt;

    // Request checks act on the live inputs so an illegal access never leaves IDLE for RD/WR.
    always_comb begin
        misaligned = 1'b0;
        case (cpu.op)
            OP_LW, OP_SW:          misaligned = |cpu.addr[1:0];
            OP_LH, OP_LHU, OP_SH:  misaligned = cpu.addr[0];
            default:               misaligned = 1'b0;
        endcase
    end

    assign out_of_range  = (cpu.addr < ADDR_LO) || (cpu.addr > ADDR_HI);
    assign req_bad       = misaligned | out_of_range;
    assign accept        = (state == S_IDLE) && cpu.start;
    assign subword_store = (op_q == OP_SH) || (op_q == OP_SB);
    assign word_addr     = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cpu.busy       = 1'b1;
        cpu.done       = 1'b0;
        mem.memWE      = 1'b0;
        mem.memAddr    = 32'h0;
        mem.memDataOut = 32'h0;
        case (state)
            S_IDLE: begin
                cpu.busy = 1'b0;
                if (cpu.start) begin
                    if (req_bad) begin
                        state_nxt = S_RESP;
                    end else if (cpu.op == OP_SW) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                mem.memAddr = word_addr;
                state_nxt   = S_EXT;
            end
            S_EXT: begin
                state_nxt = subword_store ? S_WR : S_RESP;
            end
            S_WR: begin
                // Gating with reset keeps the reset edge from committing a half-finished store.
                mem.memWE      = ~reset;
                mem.memAddr    = word_addr;
                mem.memDataOut = (op_q == OP_SW) ? wdata_q : merged_q;
                state_nxt      = S_RESP;
            end
            S_RESP: begin
                cpu.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Big-endian lanes: byte offset 0 is the most significant byte of the word.
    always_comb begin
        byte_lane = 8'h0;
        case (addr_q[1:0])
            2'd0:    byte_lane = mem.memDataIn[31:24];
            2'd1:    byte_lane = mem.memDataIn[23:16];
            2'd2:    byte_lane = mem.memDataIn[15:8];
            default: byte_lane = mem.memDataIn[7:0];
        endcase
        half_lane = addr_q[1] ? mem.memDataIn[15:0] : mem.memDataIn[31:16];
    end

    always_comb begin
        load_val = mem.memDataIn;
        case (op_q)
            OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
            OP_LHU:  load_val = {16'h0, half_lane};
            OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
            OP_LBU:  load_val = {24'h0, byte_lane};
            default: load_val = mem.memDataIn;
        endcase
    end

    always_comb begin
        merged_nxt = mem.memDataIn;
        if (op_q == OP_SH) begin
            if (addr_q[1]) begin
                merged_nxt = {mem.memDataIn[31:16], wdata_q[15:0]};
            end else begin
                merged_nxt = {wdata_q[15:0], mem.memDataIn[15:0]};
            end
        end else begin
            case (addr_q[1:0])
                2'd0:    merged_nxt = {wdata_q[7:0], mem.memDataIn[23:0]};
                2'd1:    merged_nxt = {mem.memDataIn[31:24], wdata_q[7:0], mem.memDataIn[15:0]};
                2'd2:    merged_nxt = {mem.memDataIn[31:16], wdata_q[7:0], mem.memDataIn[7:0]};
                default: merged_nxt = {mem.memDataIn[31:8], wdata_q[7:0]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_LW;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merged_q <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= cpu.op;
                addr_q  <= cpu.addr;
                wdata_q <= cpu.wdata;
                err_q   <= req_bad;
                if (req_bad) begin
                    rdata_q <= 32'h0;
                end
            end
            if (state == S_EXT) begin
                if (subword_store) begin
                    merged_q <= merged_nxt;
                end else begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    assign cpu.err   = err_q;
    assign cpu.rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural 1-cycle-latency memory plus a reference word array;
// expectations are queued at issue and compared when done is seen.
module tb_load_store_unit;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        chk;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        timeout;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   touch_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;

    logic        pl_en = 1'b0;
    logic [31:0] pl_a = 32'h0;
    logic [31:0] pl_d = 32'h0;

    logic [31:0] mem_arr [0:1023];
    logic [31:0] ref_mem [0:1023];
    exp_t        sb [$];

    always #5 clk = ~clk;

    lsu_cpu_if cpu ();
    lsu_mem_if mem_bus ();

    load_store_unit #(.ADDR_LO(32'h3000), .ADDR_HI(32'h3FFF)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu),
        .mem   (mem_bus)
    );

    function automatic logic in_win(input logic [31:0] a);
        return (a >= 32'h3000) && (a <= 32'h3FFF);
    endfunction

    function automatic logic [9:0] widx(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'h3000;
        return d[11:2];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory; also records every write it actually receives.
    always @(posedge clk) begin
        if (mem_bus.memWE === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            last_wr_addr = mem_bus.memAddr;
            last_wr_data = mem_bus.memDataOut;
            if (in_win(mem_bus.memAddr)) mem_arr[widx(mem_bus.memAddr)] <= mem_bus.memDataOut;
        end
        if (pl_en) mem_arr[widx(pl_a)] <= pl_d;
        mem_bus.memDataIn <= in_win(mem_bus.memAddr) ? mem_arr[widx(mem_bus.memAddr)] : 32'h0;
    end

    always @(negedge clk) begin
        if (mem_bus.memWE === 1'b1 || mem_bus.memAddr !== 32'h0) touch_cnt = touch_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ref_mem[widx(a)] = d;
        pl_a = a;
        pl_d = d;
        pl_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Reference model: independent shift/mask formulation of the lane map.
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w, output exp_t e);
        logic        mis;
        logic [31:0] word;
        logic [31:0] m;
        logic [7:0]  b;
        logic [15:0] h;
        int          bs;
        int          hs;
        mis = ((o == LW || o == SW) && a[1:0] != 2'b00) || ((o == LH || o == LHU || o == SH) && a[0]);
        e.chk = 1'b1;
        e.rdata = 32'h0;
        e.acc = 0;
        e.err = 1'b0;
        e.lat = 3;
        if (mis || a < 32'h3000 || a > 32'h3FFF) begin
            e.err = 1'b1;
            e.lat = 1;
            return;
        end
        word = ref_mem[widx(a)];
        bs = 8 * (3 - int'(a[1:0]));
        hs = 16 * (1 - int'(a[1]));
        b = 8'(word >> bs);
        h = 16'(word >> hs);
        case (o)
            LW:  e.rdata = word;
            LH:  e.rdata = {{16{h[15]}}, h};
            LHU: e.rdata = {16'h0, h};
            LB:  e.rdata = {{24{b[7]}}, b};
            LBU: e.rdata = {24'h0, b};
            SW: begin
                e.chk = 1'b0; e.lat = 2;
                ref_mem[widx(a)] = w;
            end
            SH: begin
                e.chk = 1'b0; e.lat = 4;
                m = 32'hFFFF << hs;
                ref_mem[widx(a)] = (word & ~m) | ((32'(w[15:0])) << hs);
            end
            default: begin
                e.chk = 1'b0; e.lat = 4;
                m = 32'hFF << bs;
                ref_mem[widx(a)] = (word & ~m) | ((32'(w[7:0])) << bs);
            end
        endcase
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w, output obs_t ob);
        exp_t e;
        int   n;
        ob.timeout = 1'b0;
        ob.rdata = 32'h0;
        ob.err = 1'b0;
        ob.lat = 0;
        n = 0;
        while (cpu.busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cpu.op = o;
        cpu.addr = a;
        cpu.wdata = w;
        cpu.start = 1'b1;
        model_op(o, a, w, e);
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        cpu.start = 1'b0;
        n = 0;
        while (cpu.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cpu.done !== 1'b1) begin
            ob.timeout = 1'b1;
        end else begin
            ob.rdata = cpu.rdata;
            ob.err = cpu.err;
            ob.lat = cyc - e.acc;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu.start = 1'b0;
        cpu.op = LW;
        cpu.addr = 32'h0;
        cpu.wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu.busy, cpu.done, cpu.err, mem_bus.memWE} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy,done,err,memWE=%b required 0000", {cpu.busy, cpu.done, cpu.err, mem_bus.memWE});
        end
        checks++;
        if (cpu.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 00000000", cpu.rdata);
        end
        checks++;
        if (mem_bus.memAddr !== 32'h0 || mem_bus.memDataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_membus: memAddr=%h memDataOut=%h required 0", mem_bus.memAddr, mem_bus.memDataOut);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loads();
        logic [2:0]  ops [9] = '{LB, LBU, LB, LBU, LH, LHU, LH, LW, LB};
        logic [31:0] ads [9] = '{32'h3FFC, 32'h3FFD, 32'h3FFE, 32'h3FFF, 32'h3FFC, 32'h3FFE, 32'h3FFE, 32'h3FFC, 32'h3FFD};
        logic [31:0] exv [9] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_007F, 32'h0000_0001, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h0000_7F01, 32'h80FF_7F01, 32'hFFFF_FFFF};
        obs_t ob;
        exp_t e;
        preload(32'h3FFC, 32'h80FF_7F01);
        for (int i = 0; i < 9; i++) begin
            do_op(ops[i], ads[i], 32'h0, ob);
            e = sb.pop_front();
            checks++;
            if (ob.timeout || ob.err !== e.err || ob.lat !== e.lat || (e.chk && ob.rdata !== e.rdata)) begin
                errors++;
                $display("FAIL load_%0d: rdata=%h err=%b lat=%0d timeout=%b required rdata=%h err=%b lat=%0d",
                         i, ob.rdata, ob.err, ob.lat, ob.timeout, e.rdata, e.err, e.lat);
            end
            checks++;
            if (ob.rdata !== exv[i]) begin
                errors++;
                $display("FAIL load_const_%0d: rdata=%h required %h", i, ob.rdata, exv[i]);
            end
        end
    endtask

    task automatic test_store_word();
        obs_t ob;
        exp_t e;
        int   w0;
        w0 = wr_cnt;
        do_op(SW, 32'h3000, 32'hDEAD_BEEF, ob);
        e = sb.pop_front();
        checks++;
        if (ob.timeout || ob.err !== e.err || ob.lat !== e.lat) begin
            errors++;
            $display("FAIL sw: err=%b lat=%0d timeout=%b required err=%b lat=%0d", ob.err, ob.lat, ob.timeout, e.err, e.lat);
        end
        checks++;
        if (wr_cnt - w0 != 1 || last_wr_addr !== 32'h3000 || last_wr_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_bus: writes=%0d addr=%h data=%h required 1 write of DEADBEEF at 00003000",
                     wr_cnt - w0, last_wr_addr, last_wr_data);
        end
        do_op(LW, 32'h3000, 32'h0, ob);
        e = sb.pop_front();
        checks++;
        if (ob.timeout || ob.err !== e.err || ob.lat !== e.lat || ob.rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL lw_after_sw: rdata=%h err=%b lat=%0d required rdata=deadbeef err=0 lat=%0d",
                     ob.rdata, ob.err, ob.lat, e.lat);
        end
    endtask

    task automatic test_subword();
        logic [2:0]  ops [6] = '{SB, SH, LH, LHU, SB, LB};
        logic [31:0] ads [6] = '{32'h3006, 32'h3004, 32'h3004, 32'h3006, 32'h3007, 32'h3007};
        logic [31:0] wds [6] = '{32'h0000_00AA, 32'h0000_5566, 32'h0, 32'h0, 32'h1234_5680, 32'h0};
        logic [31:0] exv [6] = '{32'h1122_AA44, 32'h5566_AA44, 32'h0000_5566, 32'h0000_AA44, 32'h5566_AA80, 32'hFFFF_FF80};
        logic [31:0] obs_v;
        obs_t ob;
        exp_t e;
        preload(32'h3004, 32'h1122_3344);
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], ads[i], wds[i], ob);
            e = sb.pop_front();
            checks++;
            if (ob.timeout || ob.err !== e.err || ob.lat !== e.lat || (e.chk && ob.rdata !== e.rdata)) begin
                errors++;
                $display("FAIL subword_%0d: rdata=%h err=%b lat=%0d timeout=%b required rdata=%h err=%b lat=%0d",
                         i, ob.rdata, ob.err, ob.lat, ob.timeout, e.rdata, e.err, e.lat);
            end
            obs_v = ops[i][2] && ops[i] != LBU ? mem_arr[widx(32'h3004)] : ob.rdata;
            checks++;
            if (obs_v !== exv[i]) begin
                errors++;
                $display("FAIL subword_const_%0d: value=%h required %h", i, obs_v, exv[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [2:0]  ops [8] = '{LW, SH, LB, SW, LHU, LW, SB, SW};
        logic [31:0] ads [8] = '{32'h3002, 32'h3001, 32'h2FFF, 32'h4000, 32'h3FFF, 32'hFFFF_FFFC, 32'h0, 32'h3FFD};
        obs_t ob;
        exp_t e;
        int   w0;
        int   t0;
        for (int i = 0; i < 8; i++) begin
            w0 = wr_cnt;
            t0 = touch_cnt;
            do_op(ops[i], ads[i], 32'hFFFF_FFFF, ob);
            e = sb.pop_front();
            #1;
            checks++;
            if (ob.timeout || ob.err !== 1'b1 || ob.lat !== 1 || ob.rdata !== 32'h0 || e.err !== 1'b1) begin
                errors++;
                $display("FAIL err_%0d: rdata=%h err=%b lat=%0d timeout=%b required rdata=0 err=1 lat=1",
                         i, ob.rdata, ob.err, ob.lat, ob.timeout);
            end
            checks++;
            if (wr_cnt != w0 || touch_cnt != t0) begin
                errors++;
                $display("FAIL err_nomem_%0d: writes=%0d bus_active_cycles=%0d required 0 and 0",
                         i, wr_cnt - w0, touch_cnt - t0);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        obs_t ob;
        exp_t e;
        int   w0;
        preload(32'h3200, 32'h0102_0304);
        w0 = wr_cnt;
        cpu.op = SB;
        cpu.addr = 32'h3201;
        cpu.wdata = 32'h0000_00EE;
        cpu.start = 1'b1;
        @(negedge clk);
        cpu.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_bus.memWE !== 1'b1 || cpu.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_wr_cycle: memWE=%b busy=%b required 1 1", mem_bus.memWE, cpu.busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_bus.memWE !== 1'b0) begin
            errors++;
            $display("FAIL abort_we_gate: memWE=%b required 0", mem_bus.memWE);
        end
        @(negedge clk);
        checks++;
        if (cpu.busy !== 1'b0 || cpu.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b required 0 0", cpu.busy, cpu.done);
        end
        checks++;
        if (wr_cnt != w0 || mem_arr[widx(32'h3200)] !== 32'h0102_0304) begin
            errors++;
            $display("FAIL abort_nowrite: writes=%0d word=%h required 0 writes, 01020304", wr_cnt - w0, mem_arr[widx(32'h3200)]);
        end
        reset = 1'b0;
        @(negedge clk);
        do_op(LW, 32'h3200, 32'h0, ob);
        e = sb.pop_front();
        checks++;
        if (ob.timeout || ob.err !== e.err || ob.lat !== e.lat || ob.rdata !== 32'h0102_0304) begin
            errors++;
            $display("FAIL abort_lw: rdata=%h err=%b lat=%0d required rdata=01020304 err=0 lat=%0d",
                     ob.rdata, ob.err, ob.lat, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic prev_done;
        logic prev_acc;
        int   k;
        int   n_done;
        k = 0;
        n_done = 0;
        prev_done = 1'b0;
        prev_acc = 1'b0;
        @(negedge clk);
        cpu.start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (cpu.done === 1'b1) begin
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL b2b_done_width: done high on consecutive cycles at cycle %0d", cyc);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_done: done with no outstanding request at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cpu.err !== e.err || (cyc - e.acc) !== e.lat || (e.chk && cpu.rdata !== e.rdata)) begin
                        errors++;
                        $display("FAIL b2b_%0d: rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                                 n_done, cpu.rdata, cpu.err, cyc - e.acc, e.rdata, e.err, e.lat);
                    end
                end
                n_done++;
            end
            if (prev_acc) begin
                checks++;
                if (cpu.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_busy: busy=%b required 1 after accept", cpu.busy);
                end
            end
            prev_done = cpu.done;
            prev_acc = 1'b0;
            if (k >= 10) cpu.start = 1'b0;
            if (cpu.busy === 1'b0 && k < 10) begin
                cpu.op = k[0] ? LW : SW;
                cpu.addr = 32'h3100;
                cpu.wdata = 32'hA5A5_0000 + 32'(k);
                model_op(cpu.op, cpu.addr, cpu.wdata, e);
                e.acc = cyc;
                sb.push_back(e);
                prev_acc = 1'b1;
                k++;
            end
            if (k >= 10 && sb.size() == 0 && !prev_acc) break;
            @(negedge clk);
        end
        cpu.start = 1'b0;
        checks++;
        if (n_done != 10 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: dones=%0d outstanding=%0d required 10 and 0", n_done, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_store_word();
        test_subword();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port. Executes one CPU load/store per request against a word-wide memory.
- The memory has one synchronous read port with 1-cycle latency, a word-only write enable and byte addressing. Its valid window is ADDR_LO..ADDR_HI.
- Handles sub-word stores by read-modify-write. Extracts and extends sub-word loads. Flags misaligned and out-of-range accesses without touching memory.

Parameters:
ADDR_LO, 32'h3000, lowest legal byte address (inclusive)
ADDR_HI, 32'h3FFF, highest legal byte address (inclusive)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
start  in  1  request strobe; sampled only when busy=0
op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
addr  in  32  byte address of access
wdata  in  32  store data; SH uses [15:0], SB uses [7:0]
busy  out  1  high from the cycle after accept until the done cycle, inclusive
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = misaligned or out of range, no memory access made
rdata  out  32  load result, valid with done, held until next done
memWE  out  1  to memory write enable
memAddr  out  32  to memory address (always word-aligned: addr & ~3)
memDataOut  out  32  to memory write data
memDataIn  in  32  from memory read data; valid the cycle after memAddr is presented

Behaviour:
- Reset (sync): state=IDLE, busy=0, done=0, err=0, rdata=0, memWE=0, memAddr=0, memDataOut=0.
- memWE = (state==WR) & ~reset. Reset in any state aborts the operation, and no write occurs at the reset edge.
- Accept: when state=IDLE and start=1, latch op, addr, wdata. start is ignored while busy=1.
- Checks at accept:
  - Misaligned: LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]≠0.
  - Out of range: addr<ADDR_LO or addr>ADDR_HI.
  - On either condition, go to RESP with err=1 and rdata=0. No RD/WR state is entered.
- States:
  - IDLE: busy=0, memWE=0.
  - RD: memAddr=word address, memWE=0. Memory samples the address at the end of this cycle.
  - EXT: memDataIn is valid.
    - Loads: register the extracted value into rdata, then go to RESP.
    - SH/SB: register merged = memDataIn with the target lane replaced, then go to WR.
  - WR: memWE=1, memAddr=word address, memDataOut = wdata (SW) or merged (SH/SB). Then go to RESP.
  - RESP: done=1 for one cycle, busy=1. Then go to IDLE. A start in this cycle is ignored.
- Lane map (big-endian):
  - Bytes: offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
  - Halfwords: offset 0 = [31:16], 2 = [15:0].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Paths:
  - LW/LH/LHU/LB/LBU: IDLE→RD→EXT→RESP.
  - SW: IDLE→WR→RESP.
  - SH/SB: IDLE→RD→EXT→WR→RESP.
  - Error: IDLE→RESP.
- Latency (cycles from accept edge to done=1): loads 3, SW 2, SH/SB 4, error 1.
- Only the target lane changes on a sub-word store; the other three bytes are rewritten with the values read in EXT.
- memAddr is 0 in IDLE and in error paths.
- No address wrap: addr arithmetic never carries. The range check uses the full 32-bit unsigned compare.
- Back-to-back operation: a new start is accepted in the first IDLE cycle after RESP. Throughput for LW is therefore one per 4 cycles.

Test Plan:
1. Preload mem[0x3FFC]=0x80FF_7F01. Issue LB at 0x3FFC → done 3 cycles after accept, rdata=0xFFFF_FF80, err=0. Issue LBU at 0x3FFD → rdata=0x0000_00FF.
2. SW 0xDEAD_BEEF at 0x3000 → memWE high exactly 1 cycle with memAddr=0x3000, done 2 cycles after accept. Then LW at 0x3000 → rdata=0xDEAD_BEEF.
3. With mem[0x3004]=0x1122_3344: SB wdata=0xAA at 0x3006 → memory 0x1122_AA44, done 4 cycles after accept. Then SH wdata=0x5566 at 0x3004 → 0x5566_AA44. Then LH at 0x3004 → 0x0000_5566; LHU at 0x3006 → 0x0000_AA44.
4. LW at 0x3002, SH at 0x3001, LB at 0x2FFF, SW at 0x4000 → each gives err=1, rdata=0, done 1 cycle after accept, memWE never asserted.
5. Assert reset in the WR cycle of an SB → no write occurs (memory unchanged), busy=0 and done=0 next cycle. A following LW returns the old value.
6. Hold start=1 continuously with alternating LW/SW → a request is accepted only in IDLE cycles, and every done is exactly one cycle wide.
